// File: rtl/ifetch.sv
// Instruction fetch: one outstanding word request, a single-entry instruction register and branch redirect.
// Optional IFETCH_ALIGN_TRAP_EN: misaligned branch targets trap into a sticky FAULT state with a fault port.
module ifetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_addr,
  output logic        i_req,
  input  logic        i_ack,
  input  logic [31:0] i_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc4,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target
`ifdef IFETCH_ALIGN_TRAP_EN
  ,
  output logic        fault
`endif
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_KILL, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc4_q, ir_pc4_d;
  logic        ir_valid_q, ir_valid_d;
  logic [31:0] tgt;
  logic        trap;

  assign tgt = {br_target[31:2], 2'b00};

`ifdef IFETCH_ALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign trap  = br_taken && (br_target[1:0] != 2'b00);
  assign fault = fault_q;
`else
  logic unused_tgt_lo;
  assign unused_tgt_lo = ^br_target[1:0];
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_pc4_d   = ir_pc4_q;
    ir_valid_d = ir_valid_q;
`ifdef IFETCH_ALIGN_TRAP_EN
    fault_d    = fault_q;
`endif
    if (trap && state_q != S_FAULT) begin
      state_d    = S_FAULT;
      ir_valid_d = 1'b0;
`ifdef IFETCH_ALIGN_TRAP_EN
      fault_d    = 1'b1;
`endif
    end else begin
      case (state_q)
        S_REQ: begin
          if (br_taken) begin
            pc_d = tgt;
            // Unacked request must stay on the bus: remember its address and wait it out.
            if (!i_ack) begin
              addr_d  = pc_q;
              state_d = S_KILL;
            end
          end else if (i_ack) begin
            ir_d       = i_rdata;
            ir_pc4_d   = pc_q + 32'd4;
            pc_d       = pc_q + 32'd4;
            ir_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (br_taken) begin
            pc_d       = tgt;
            ir_valid_d = 1'b0;
            state_d    = S_REQ;
          end else if (ir_ready) begin
            ir_valid_d = 1'b0;
            state_d    = S_REQ;
          end
        end
        S_KILL: begin
          if (br_taken) pc_d = tgt;
          if (i_ack) state_d = S_REQ;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_VECTOR;
      addr_q     <= RESET_VECTOR;
      ir_q       <= '0;
      ir_pc4_q   <= '0;
      ir_valid_q <= 1'b0;
`ifdef IFETCH_ALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_pc4_q   <= ir_pc4_d;
      ir_valid_q <= ir_valid_d;
`ifdef IFETCH_ALIGN_TRAP_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign i_req    = (state_q == S_REQ) || (state_q == S_KILL);
  assign i_addr   = (state_q == S_KILL) ? addr_q : pc_q;
  assign ir       = ir_q;
  assign ir_pc4   = ir_pc4_q;
  assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus a randomized run against a sequential-program model.
module tb_ifetch;
  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_addr;
  logic        i_req;
  logic        i_ack = 1'b0;
  logic [31:0] i_rdata = '0;
  logic [31:0] ir, ir_pc4;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
`ifdef IFETCH_ALIGN_TRAP_EN
  logic        fault;
`endif

  int checks = 0;
  int failures = 0;

  ifetch #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .i_addr(i_addr), .i_req(i_req), .i_ack(i_ack),
    .i_rdata(i_rdata), .ir(ir), .ir_pc4(ir_pc4), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .br_taken(br_taken), .br_target(br_target)
`ifdef IFETCH_ALIGN_TRAP_EN
    , .fault(fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
    checks++; if (i_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", i_req); end
    checks++; if (i_addr !== RV) begin failures++; $display("FAIL reset_addr got=%h exp=%h", i_addr, RV); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ir_valid); end
    checks++; if (ir !== 32'h0 || ir_pc4 !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h/%h exp=0/0", ir, ir_pc4); end
`ifdef IFETCH_ALIGN_TRAP_EN
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
`endif
  endtask

  task automatic test_fetch_hold();
    i_ack = 1'b1; i_rdata = 32'h1234_5678; tick();
    i_ack = 1'b0; i_rdata = '0;
    checks++; if (ir_valid !== 1'b1 || ir !== 32'h1234_5678 || ir_pc4 !== 32'h104)
      begin failures++; $display("FAIL fetch_first got=%b %h %h exp=1 12345678 00000104", ir_valid, ir, ir_pc4); end
    for (int i = 0; i < 5; i++) begin
      ir_ready = 1'b0; tick();
      checks++; if (ir_valid !== 1'b1 || ir !== 32'h1234_5678 || ir_pc4 !== 32'h104 || i_req !== 1'b0)
        begin failures++; $display("FAIL hold_stall%0d got=%b %h %h req=%b", i, ir_valid, ir, ir_pc4, i_req); end
    end
    ir_ready = 1'b1; tick(); ir_ready = 1'b0;
    checks++; if (i_req !== 1'b1 || i_addr !== 32'h104 || ir_valid !== 1'b0)
      begin failures++; $display("FAIL hold_release got=req%b %h v%b exp=req1 00000104 v0", i_req, i_addr, ir_valid); end
    i_ack = 1'b1; i_rdata = 32'h0BAD_F00D; tick(); i_ack = 1'b0;
    ir_ready = 1'b1; tick(); ir_ready = 1'b0;
    checks++; if (i_addr !== 32'h108 || i_req !== 1'b1)
      begin failures++; $display("FAIL seq_addr got=%h exp=00000108", i_addr); end
  endtask

  task automatic test_branch_kill();
    br_taken = 1'b1; br_target = 32'h200; tick(); br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (i_addr !== 32'h108 || i_req !== 1'b1)
        begin failures++; $display("FAIL kill_wait%0d got=%h req=%b exp=00000108 req=1", i, i_addr, i_req); end
      tick();
    end
    i_ack = 1'b1; i_rdata = 32'hDEAD_BEEF; tick(); i_ack = 1'b0;
    checks++; if (i_addr !== 32'h200 || i_req !== 1'b1 || ir_valid !== 1'b0)
      begin failures++; $display("FAIL kill_redirect got=%h req=%b v=%b exp=00000200 1 0", i_addr, i_req, ir_valid); end
  endtask

  task automatic test_br_with_ack();
    i_ack = 1'b1; i_rdata = 32'h7777_7777; br_taken = 1'b1; br_target = 32'h40; tick();
    i_ack = 1'b0; br_taken = 1'b0;
    checks++; if (ir_valid !== 1'b0 || i_addr !== 32'h40 || i_req !== 1'b1)
      begin failures++; $display("FAIL br_ack got=v%b %h exp=v0 00000040", ir_valid, i_addr); end
  endtask

  task automatic test_wrap();
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC; tick(); br_taken = 1'b0;
    i_ack = 1'b1; i_rdata = 32'h1; tick();
    checks++; if (i_addr !== 32'hFFFF_FFFC || ir_valid !== 1'b0)
      begin failures++; $display("FAIL wrap_target got=%h v%b exp=fffffffc v0", i_addr, ir_valid); end
    i_rdata = 32'hCAFE_0001; tick(); i_ack = 1'b0;
    checks++; if (ir_valid !== 1'b1 || ir !== 32'hCAFE_0001 || ir_pc4 !== 32'h0)
      begin failures++; $display("FAIL wrap_pc4 got=v%b %h %h exp=v1 cafe0001 00000000", ir_valid, ir, ir_pc4); end
    ir_ready = 1'b1; tick(); ir_ready = 1'b0;
    checks++; if (i_addr !== 32'h0 || i_req !== 1'b1)
      begin failures++; $display("FAIL wrap_addr got=%h exp=00000000", i_addr); end
  endtask

  task automatic test_misalign();
    br_taken = 1'b1; br_target = 32'h202; tick(); br_taken = 1'b0;
`ifdef IFETCH_ALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      checks++; if (fault !== 1'b1 || i_req !== 1'b0 || ir_valid !== 1'b0)
        begin failures++; $display("FAIL trap%0d got=f%b req%b v%b exp=f1 req0 v0", i, fault, i_req, ir_valid); end
      i_ack = 1'($urandom_range(0, 1)); ir_ready = 1'b1; tick();
    end
    i_ack = 1'b0; ir_ready = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (fault !== 1'b0 || i_req !== 1'b1 || i_addr !== RV)
      begin failures++; $display("FAIL trap_exit got=f%b req%b %h exp=f0 req1 %h", fault, i_req, i_addr, RV); end
`else
    i_ack = 1'b1; i_rdata = 32'h3; tick(); i_ack = 1'b0;
    checks++; if (i_addr !== 32'h200 || i_req !== 1'b1)
      begin failures++; $display("FAIL misalign_force got=%h exp=00000200", i_addr); end
`endif
  endtask

  task automatic test_reset_mid();
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (i_req !== 1'b1 || i_addr !== RV)
      begin failures++; $display("FAIL midreset_addr got=req%b %h exp=req1 %h", i_req, i_addr, RV); end
    i_ack = 1'b1; i_rdata = 32'h5555_AAAA; tick(); i_ack = 1'b0;
    checks++; if (ir_valid !== 1'b1 || ir !== 32'h5555_AAAA || ir_pc4 !== RV + 32'd4)
      begin failures++; $display("FAIL midreset_stale got=v%b %h %h exp=v1 5555aaaa %h", ir_valid, ir, ir_pc4, RV + 32'd4); end
  endtask

  // Model: instructions are delivered in program order from exp_pc; a redirect restarts the order at the target.
  task automatic test_random();
    logic [31:0] exp_pc, prev_ir, prev_pc4, prev_addr;
    logic        prev_valid, waiting;
    int          lat, delivered;
    exp_pc = RV; prev_valid = 1'b0; waiting = 1'b0; lat = 0; delivered = 0;
    prev_ir = '0; prev_pc4 = '0; prev_addr = '0;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (waiting) begin
        checks++; if (i_req !== 1'b1 || i_addr !== prev_addr)
          begin failures++; $display("FAIL rnd_stable c=%0d got=req%b %h exp=req1 %h", c, i_req, i_addr, prev_addr); end
      end
      if (ir_valid && !prev_valid) begin
        delivered++;
        checks++; if (ir !== mem_word(exp_pc) || ir_pc4 !== exp_pc + 32'd4)
          begin failures++; $display("FAIL rnd_instr c=%0d got=%h %h exp=%h %h", c, ir, ir_pc4, mem_word(exp_pc), exp_pc + 32'd4); end
      end else if (ir_valid && prev_valid) begin
        checks++; if (ir !== prev_ir || ir_pc4 !== prev_pc4 || i_req !== 1'b0)
          begin failures++; $display("FAIL rnd_hold c=%0d got=%h %h exp=%h %h", c, ir, ir_pc4, prev_ir, prev_pc4); end
      end
      if (i_req) begin
        if (!waiting) lat = $urandom_range(0, 3);
        i_ack = (lat == 0);
        if (lat != 0) lat--;
        i_rdata = i_ack ? mem_word(i_addr) : $urandom;
      end else begin
        i_ack = 1'($urandom_range(0, 1));
        i_rdata = $urandom;
      end
      ir_ready = ($urandom_range(0, 2) != 0);
      br_taken = ($urandom_range(0, 9) == 0);
`ifdef IFETCH_ALIGN_TRAP_EN
      br_target = {$urandom, 2'b00} >> 2 << 2;
`else
      br_target = $urandom;
`endif
      if (br_taken) br_target[31:24] = 8'($urandom_range(0, 1) ? 8'hFF : 8'h00);
      if (br_taken) exp_pc = {br_target[31:2], 2'b00};
      else if (ir_valid && ir_ready) exp_pc = exp_pc + 32'd4;
      waiting = i_req && !i_ack;
      prev_addr = i_addr; prev_valid = ir_valid; prev_ir = ir; prev_pc4 = ir_pc4;
      tick();
    end
    i_ack = 1'b0; ir_ready = 1'b0; br_taken = 1'b0;
    checks++; if (delivered < 100)
      begin failures++; $display("FAIL rnd_liveness got=%0d exp>=100", delivered); end
  endtask

  initial begin
    test_reset();
    test_fetch_hold();
    test_branch_kill();
    test_br_with_ack();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
